// File: rtl/rv32ima_pkg.sv
// ---------------------------------------------------------------------------
// rv32ima_pkg -- shared types for the rv32ima memory subsystem.
//   word_t      : 32-bit machine word.
//   ramstate_t  : handshake state reported by the RAM (FREE/BUSY/ACCESS/ERROR).
//   arb_state_t : mem_arbiter grant state (IDLE/IGRANT/DGRANT).
// ---------------------------------------------------------------------------
package rv32ima_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

    // Fetches always read a full word.
    localparam logic [3:0] BYTEEN_ALL = 4'b1111;

    // True while the RAM is owned by one of the requesters.
    function automatic logic is_grant(input arb_state_t s);
        return (s == IGRANT) || (s == DGRANT);
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// ---------------------------------------------------------------------------
// arb_watchdog -- grant-duration counter for mem_arbiter.
// Counts the cycles the arbiter spends in a grant state and flags expiry in
// the TIMEOUT_CYCLES-th grant cycle so the arbiter can abort the access.
// Ports:
//   clk      in  clock
//   nrst     in  asynchronous active-low reset
//   active_i in  arbiter is in a grant state this cycle
//   expire_o out current grant cycle is the last one allowed
// ---------------------------------------------------------------------------
module arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic nrst,
    input  logic active_i,
    output logic expire_o
);

    // A limit below one grant cycle is clamped to one.
    localparam int LIMIT = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;
    localparam int CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Grant-cycle counter: zero in the first grant cycle, cleared whenever idle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (!active_i) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (cnt_q != LAST) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign expire_o = active_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter -- shares one RAM port between instruction fetch and data
// load/store requesters. A request seen in IDLE is latched and granted on the
// next edge; the RAM strobes are driven from the latched copy until the RAM
// reports ACCESS (hit) or ERROR (merr). Simultaneous fetch/data requests
// alternate priority, starting with data after reset.
// Optional feature: define ARB_TIMEOUT_EN to abort grants lasting
// TIMEOUT_CYCLES cycles without RAM completion (arb_watchdog).
// Ports:
//   clk, nrst                         clock, async active-low reset
//   iren/iaddr -> ihit/iload          instruction fetch port
//   dren/dwen/daddr/dstore/dbyteen    data port request
//   dhit/dload                        data port completion
//   merr                              access aborted (instead of a hit)
//   ram_ren/ram_wen/ram_addr/
//   ram_store/ram_byteen              RAM command, registered
//   ram_state/ram_load                RAM status and read data
// ---------------------------------------------------------------------------
module mem_arbiter
    import rv32ima_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              iren,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              ihit,
    output logic [31:0]       iload,
    input  logic              dren,
    input  logic              dwen,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [31:0]       dstore,
    input  logic [3:0]        dbyteen,
    output logic              dhit,
    output logic [31:0]       dload,
    output logic              merr,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_store,
    output logic [3:0]        ram_byteen,
    input  ramstate_t         ram_state,
    input  logic [31:0]       ram_load
);

    arb_state_t        state_q;
    logic              last_d_q;
    logic              ren_q;
    logic              wen_q;
    logic [ADDR_W-1:0] addr_q;
    word_t             store_q;
    logic [3:0]        byteen_q;

    logic grant_s;
    logic wd_expire_s;
    logic take_d_s;
    logic take_i_s;
    logic access_s;
    logic error_s;
    logic done_s;
    logic ihit_s;
    logic dhit_s;
    logic merr_s;

    assign grant_s = is_grant(state_q);

`ifdef ARB_TIMEOUT_EN
    arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .nrst     (nrst),
        .active_i (grant_s),
        .expire_o (wd_expire_s)
    );
`else
    // No watchdog: a grant waits for the RAM indefinitely (a negative limit
    // cannot be configured, so this is constantly low).
    assign wd_expire_s = (TIMEOUT_CYCLES < 32'sd0);
`endif

    // Arbitration and completion decode.
    always_comb begin
        take_d_s = 1'b0;
        take_i_s = 1'b0;
        access_s = 1'b0;
        error_s  = 1'b0;
        ihit_s   = 1'b0;
        dhit_s   = 1'b0;
        merr_s   = 1'b0;
        // Data wins a tie unless it was served last.
        if ((dren || dwen) && !(iren && last_d_q)) begin
            take_d_s = 1'b1;
        end else if (iren) begin
            take_i_s = 1'b1;
        end else begin
            take_d_s = 1'b0;
        end
        if (grant_s) begin
            access_s = (ram_state == ACCESS);
            error_s  = (ram_state == ERROR);
            ihit_s   = access_s && (state_q == IGRANT);
            dhit_s   = access_s && (state_q == DGRANT);
            // A RAM completion in the expiry cycle still counts as a hit.
            merr_s   = error_s || (wd_expire_s && !access_s);
        end else begin
            merr_s   = 1'b0;
        end
        done_s = access_s || error_s || wd_expire_s;
    end

    // Grant FSM; the latched request doubles as the registered RAM command
    // and is zeroed whenever the arbiter is idle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            addr_q   <= {ADDR_W{1'b0}};
            store_q  <= 32'h0;
            byteen_q <= 4'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (take_d_s) begin
                        state_q  <= DGRANT;
                        ren_q    <= ~dwen;   // store wins over load
                        wen_q    <= dwen;
                        addr_q   <= daddr;
                        store_q  <= dstore;
                        byteen_q <= dbyteen;
                    end else if (take_i_s) begin
                        state_q  <= IGRANT;
                        ren_q    <= 1'b1;
                        wen_q    <= 1'b0;
                        addr_q   <= iaddr;
                        store_q  <= 32'h0;
                        byteen_q <= BYTEEN_ALL;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                IGRANT, DGRANT: begin
                    if (done_s) begin
                        state_q  <= IDLE;
                        last_d_q <= (state_q == DGRANT);
                        ren_q    <= 1'b0;
                        wen_q    <= 1'b0;
                        addr_q   <= {ADDR_W{1'b0}};
                        store_q  <= 32'h0;
                        byteen_q <= 4'h0;
                    end else begin
                        state_q  <= state_q;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    ren_q    <= 1'b0;
                    wen_q    <= 1'b0;
                    addr_q   <= {ADDR_W{1'b0}};
                    store_q  <= 32'h0;
                    byteen_q <= 4'h0;
                end
            endcase
        end
    end

    assign ram_ren    = ren_q;
    assign ram_wen    = wen_q;
    assign ram_addr   = addr_q;
    assign ram_store  = store_q;
    assign ram_byteen = byteen_q;

    // Completion is reported in the same cycle the RAM signals it.
    assign ihit  = ihit_s;
    assign dhit  = dhit_s;
    assign merr  = merr_s;
    assign iload = ihit_s ? ram_load : 32'h0;
    assign dload = dhit_s ? ram_load : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter -- scoreboard bench for mem_arbiter. The stimulus process
// plays both requesters and the RAM; for every transaction it predicts the
// winner, the RAM command and the completion from the arbitration rules and
// queues the expectation. A monitor on the falling edge checks the RAM
// command every cycle and pops/compares on every hit or merr.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;
    import rv32ima_pkg::*;

`ifdef ARB_TIMEOUT_EN
    localparam int TB_TO = 8;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TB_TO = 255;
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nrst;
    logic        iren, dren, dwen;
    logic [31:0] iaddr, daddr, dstore;
    logic [3:0]  dbyteen;
    logic        ihit, dhit, merr;
    logic [31:0] iload, dload;
    logic        ram_ren, ram_wen;
    logic [31:0] ram_addr, ram_store, ram_load;
    logic [3:0]  ram_byteen;
    ramstate_t   ram_state;

    mem_arbiter #(.TIMEOUT_CYCLES(TB_TO), .ADDR_W(32)) dut (
        .clk(clk), .nrst(nrst),
        .iren(iren), .iaddr(iaddr), .ihit(ihit), .iload(iload),
        .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore),
        .dbyteen(dbyteen), .dhit(dhit), .dload(dload), .merr(merr),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_store(ram_store), .ram_byteen(ram_byteen),
        .ram_state(ram_state), .ram_load(ram_load)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        bit          is_w;
        bit          err;
        logic [31:0] addr;
        logic [31:0] store;
        logic [31:0] load;
        logic [3:0]  byteen;
        int          cyc;
    } exp_t;

    typedef struct packed {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
        logic [3:0]  be;
    } bus_t;

    exp_t sbq[$];
    bus_t exp_bus = '0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   model_last_d = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: RAM command every cycle, responses against the scoreboard.
    exp_t        me;
    logic [2:0]  resp;
    logic [31:0] exp_il, exp_dl;
    always @(negedge clk) begin
        resp = {ihit, dhit, merr};
        chk("ram_strobes", 64'({ram_ren, ram_wen}), 64'({exp_bus.ren, exp_bus.wen}));
        chk("ram_addr", 64'(ram_addr), 64'(exp_bus.addr));
        chk("ram_store", 64'(ram_store), 64'(exp_bus.store));
        chk("ram_byteen", 64'(ram_byteen), 64'(exp_bus.be));
        if (!ihit) chk("iload_gated", 64'(iload), 64'd0);
        if (!dhit) chk("dload_gated", 64'(dload), 64'd0);
        if (resp != 3'b000) begin
            if (sbq.size() == 0) begin
                chk("spurious_resp", 64'(resp), 64'd0);
            end else begin
                me = sbq.pop_front();
                exp_il = (!me.is_d && !me.err) ? me.load : 32'h0;
                exp_dl = ( me.is_d && !me.err) ? me.load : 32'h0;
                chk("resp_kind", 64'(resp), me.err ? 64'd1 : (me.is_d ? 64'd2 : 64'd4));
                chk("resp_load", {iload, dload}, {exp_il, exp_dl});
                chk("resp_cycle", 64'(cyc), 64'(me.cyc));
            end
        end else if (sbq.size() > 0 && cyc >= sbq[0].cyc) begin
            me = sbq.pop_front();
            chk("resp_present", 64'(resp != 3'b000), 64'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Requester inputs are don't-care while a grant is in progress.
    task automatic scramble_reqs();
        iren    = 1'($urandom_range(0, 1));
        dren    = 1'($urandom_range(0, 1));
        dwen    = 1'($urandom_range(0, 1));
        iaddr   = $urandom();
        daddr   = $urandom();
        dstore  = $urandom();
        dbyteen = 4'($urandom_range(0, 15));
    endtask

    // One request cycle in IDLE followed by the whole grant the RAM plays out:
    // `busy` FREE/BUSY cycles, then ACCESS (or ERROR when err is set).
    task automatic run_txn(input logic ir, input logic dr, input logic dw,
                           input logic [31:0] ia, input logic [31:0] da,
                           input logic [31:0] ds, input logic [3:0] dbe,
                           input int busy, input bit err, input logic [31:0] ld);
        exp_t e;
        bit   take_d;
        bit   timeout;
        int   nbusy;
        iren = ir; dren = dr; dwen = dw;
        iaddr = ia; daddr = da; dstore = ds; dbyteen = dbe;
        ram_state = ramstate_t'($urandom_range(0, 3));
        ram_load  = $urandom();
        exp_bus   = '0;
        if (!(ir || dr || dw)) begin
            tick();
            return;
        end
        take_d   = (dr || dw) && !(ir && model_last_d);
        e.is_d   = take_d;
        e.is_w   = take_d && dw;
        e.addr   = take_d ? da : ia;
        e.store  = take_d ? ds : 32'h0;
        e.byteen = take_d ? dbe : 4'b1111;
        timeout  = TO_EN && (busy >= TB_TO);
        nbusy    = timeout ? TB_TO - 1 : busy;
        e.err    = err || timeout;
        e.load   = ld;
        e.cyc    = cyc + 1 + nbusy;
        sbq.push_back(e);
        tick();
        exp_bus = '{ren: !e.is_w, wen: e.is_w, addr: e.addr, store: e.store, be: e.byteen};
        for (int k = 0; k < nbusy; k++) begin
            ram_state = ($urandom_range(0, 1) != 0) ? BUSY : FREE;
            ram_load  = $urandom();
            scramble_reqs();
            tick();
        end
        scramble_reqs();
        ram_load  = ld;
        ram_state = timeout ? BUSY : (err ? ERROR : ACCESS);
        tick();
        model_last_d = take_d;
        exp_bus   = '0;
        iren = 1'b0; dren = 1'b0; dwen = 1'b0;
        ram_state = FREE;
    endtask

    logic        r_ir, r_dr, r_dw;
    logic [3:0]  r_be;
    int          r_busy;
    bit          r_err;

    initial begin
        nrst = 1'b0;
        iren = 1'b0; dren = 1'b0; dwen = 1'b0;
        iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0; dbyteen = 4'h0;
        ram_state = FREE; ram_load = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({ihit, dhit, merr, ram_ren, ram_wen, |iload, |dload,
                                  |ram_addr, |ram_store, |ram_byteen}), 64'd0);
        nrst = 1'b1;
        tick();

        // Fetch with immediate ACCESS.
        run_txn(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 4'h0, 0, 1'b0, 32'hDEADBEEF);
        // Three tied fetch/data requests alternate D, I, D.
        for (int t = 0; t < 3; t++)
            run_txn(1'b1, 1'b1, 1'b0, 32'h1000 + 32'(t), 32'h2000 + 32'(t), 32'h0, 4'hF,
                    1, 1'b0, 32'hA5A50000 + 32'(t));
        // Store after three BUSY cycles.
        run_txn(1'b0, 1'b0, 1'b1, 32'h0, 32'h200, 32'h12345678, 4'b0011, 3, 1'b0, 32'h0);
        // Load with load+store both set -> store.
        run_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h300, 32'hCAFEF00D, 4'b1100, 0, 1'b0, 32'h77);
        // ERROR in the second grant cycle.
        run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h400, 32'h0, 4'hF, 1, 1'b1, 32'h55AA55AA);
        if (TO_EN)
            run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h500, 32'h0, 4'hF, TB_TO, 1'b0, 32'h0);

        // Reset in the middle of a data grant.
        iren = 1'b0; dren = 1'b1; dwen = 1'b0;
        daddr = 32'h600; dstore = 32'h11; dbyteen = 4'b0101;
        tick();
        exp_bus = '{ren: 1'b1, wen: 1'b0, addr: 32'h600, store: 32'h11, be: 4'b0101};
        ram_state = BUSY;
        tick();
        ram_state = ACCESS;
        nrst = 1'b0;
        exp_bus = '0;
        model_last_d = 1'b0;
        #1;
        chk("reset_mid_grant", 64'({ihit, dhit, merr, ram_ren, ram_wen, |iload, |dload,
                                    |ram_addr, |ram_store, |ram_byteen}), 64'd0);
        tick();
        dren = 1'b0;
        ram_state = FREE;
        tick();
        nrst = 1'b1;
        tick();
        run_txn(1'b1, 1'b0, 1'b0, 32'h700, 32'h0, 32'h0, 4'h0, 2, 1'b0, 32'h0BADF00D);

        // Randomised traffic.
        for (int t = 0; t < 300; t++) begin
            r_ir   = ($urandom_range(0, 3) != 0);
            r_dr   = ($urandom_range(0, 2) != 0);
            r_dw   = ($urandom_range(0, 2) == 0);
            r_be   = 4'($urandom_range(0, 15));
            r_err  = ($urandom_range(0, 7) == 0);
            r_busy = ($urandom_range(0, 7) == 0)
                     ? int'($urandom_range(0, TO_EN ? TB_TO + 3 : 20))
                     : int'($urandom_range(0, 3));
            run_txn(r_ir, r_dr, r_dw, $urandom(), $urandom(), $urandom(), r_be,
                    r_busy, r_err, $urandom());
        end

        tick();
        tick();
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
